// File: rtl/ppa_digit_serial_sub.sv
// Digit-serial subtractor: diff = a - b - bin, computed DIGIT bits per cycle, LSB digit first.
// Each digit runs through a pre / black-cell prefix chain / post slice in carry form
// (a + ~b + ~bin). The carry between digits lives in a single flop.
module ppa_digit_serial_sub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned NDIG  = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  // Reject parameter sets that cannot be split into whole digits
  if ((DIGIT < 1) || ((WIDTH % ((DIGIT == 0) ? 1 : DIGIT)) != 0)) begin : g_param_check
    $error("ppa_digit_serial_sub: WIDTH (%0d) must be a nonzero multiple of DIGIT (%0d)",
           WIDTH, DIGIT);
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] nb_sh_q;
  logic             carry_q;
  logic [CNT_W-1:0] dig_cnt_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             accept_c;
  logic             last_dig_c;

  logic [DIGIT-1:0] a_dig_c;
  logic [DIGIT-1:0] nb_dig_c;
  logic [DIGIT-1:0] p_dig_c;
  logic [DIGIT:0]   gg_c;
  logic [DIGIT:0]   pp_c;
  logic [DIGIT-1:0] sum_dig_c;
  logic             cout_c;
  logic             cmsb_c;
  logic [WIDTH-1:0] diff_shift_c;

  assign accept_c   = (state_q == S_IDLE) && in_valid;
  assign last_dig_c = (dig_cnt_q == CNT_W'(NDIG - 1));

  // State register plus registered handshake outputs derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
    end
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after last digit, DONE -> IDLE on handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid)   state_d = S_RUN;
      S_RUN:  if (last_dig_c) state_d = S_DONE;
      S_DONE: if (out_ready)  state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // One digit slice: pre-processing, Kogge-Stone black-cell chain seeded with carry-in, post xor
  always_comb begin
    a_dig_c  = a_sh_q[DIGIT-1:0];
    nb_dig_c = nb_sh_q[DIGIT-1:0];
    p_dig_c  = a_dig_c ^ nb_dig_c;
    gg_c     = {a_dig_c & nb_dig_c, carry_q};
    pp_c     = {p_dig_c, 1'b0};
    for (int d = 1; d <= int'(DIGIT); d = d * 2) begin
      for (int i = int'(DIGIT); i >= d; i--) begin
        gg_c[i] = gg_c[i] | (pp_c[i] & gg_c[i-d]);
        pp_c[i] = pp_c[i] & pp_c[i-d];
      end
    end
    sum_dig_c    = p_dig_c ^ gg_c[DIGIT-1:0];
    cout_c       = gg_c[DIGIT];
    cmsb_c       = gg_c[DIGIT-1];
    diff_shift_c = (diff_q >> DIGIT) | (WIDTH'(sum_dig_c) << (WIDTH - DIGIT));
  end

  // Operand shifters, carry flop, digit counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q    <= '0;
      nb_sh_q   <= '0;
      carry_q   <= 1'b0;
      dig_cnt_q <= '0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (accept_c) begin
      a_sh_q    <= a;
      nb_sh_q   <= ~b;
      carry_q   <= ~bin;
      dig_cnt_q <= '0;
    end else if (state_q == S_RUN) begin
      a_sh_q    <= a_sh_q >> DIGIT;
      nb_sh_q   <= nb_sh_q >> DIGIT;
      carry_q   <= cout_c;
      diff_q    <= diff_shift_c;
      dig_cnt_q <= dig_cnt_q + CNT_W'(1);
      if (last_dig_c) begin
        bout_q <= ~cout_c;
        ovf_q  <= cmsb_c ^ cout_c;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ppa_digit_serial_sub.sv
// Directed and random checks for the digit-serial subtractor (WIDTH=16, DIGIT=4).
module tb_ppa_digit_serial_sub;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DIGIT = 4;
  localparam int          MAX_WAIT = 60;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  int n_vec;
  int n_err;

  ppa_digit_serial_sub #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands and hold in_valid until accepted; returns 0 on timeout
  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                      output bit ok);
    int w;
    ok = 1'b0;
    w  = 0;
    while (!in_ready && w < MAX_WAIT) begin
      tick();
      w++;
    end
    if (!in_ready) return;
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ok = 1'b1;
  endtask

  // Count edges from the accepting edge until out_valid; -1 on timeout
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat <= MAX_WAIT) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
    else lat = lat - 1;
  endtask

  // Count-ups with the accept-edge latency included: send() already consumed that edge
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                        output logic [15:0] rd, output logic rb, output logic ro, output int lat);
    bit ok;
    send(ta, tb, tbin, ok);
    lat = -1;
    rd = 'x; rb = 'x; ro = 'x;
    if (!ok) return;
    wait_result(lat);
    if (lat < 0) return;
    rd = diff; rb = bout; ro = ovf;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 16'h0 || bout !== 1'b0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset: in_ready=%b out_valid=%b diff=%h bout=%b ovf=%b, want 1 0 0000 0 0",
               in_ready, out_valid, diff, bout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] rd; logic rb, ro; int lat;
    run_op(16'h1234, 16'h0234, 1'b0, rd, rb, ro, lat);
    n_vec++;
    if (rd !== 16'h1000 || rb !== 1'b0 || ro !== 1'b0) begin
      n_err++;
      $display("FAIL basic: diff=%h bout=%b ovf=%b, want 1000 0 0", rd, rb, ro);
    end
    n_vec++;
    if (lat !== 4) begin
      n_err++;
      $display("FAIL latency: got %0d edges, want 4", lat);
    end
  endtask

  task automatic test_borrow_ripple();
    logic [15:0] rd; logic rb, ro; int lat;
    run_op(16'h0000, 16'h0001, 1'b0, rd, rb, ro, lat);
    n_vec++;
    if (rd !== 16'hFFFF || rb !== 1'b1 || ro !== 1'b0) begin
      n_err++;
      $display("FAIL ripple: diff=%h bout=%b ovf=%b, want ffff 1 0", rd, rb, ro);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] rd; logic rb, ro; int lat;
    run_op(16'h8000, 16'h0001, 1'b0, rd, rb, ro, lat);
    n_vec++;
    if (rd !== 16'h7FFF || rb !== 1'b0 || ro !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_neg: diff=%h bout=%b ovf=%b, want 7fff 0 1", rd, rb, ro);
    end
    run_op(16'h7FFF, 16'hFFFF, 1'b0, rd, rb, ro, lat);
    n_vec++;
    if (rd !== 16'h8000 || rb !== 1'b1 || ro !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_pos: diff=%h bout=%b ovf=%b, want 8000 1 1", rd, rb, ro);
    end
  endtask

  task automatic test_backpressure();
    bit ok; int lat; int bad;
    send(16'h0005, 16'h0005, 1'b1, ok);
    wait_result(lat);
    n_vec++;
    if (lat < 0 || diff !== 16'hFFFF || bout !== 1'b1 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL bin_wrap: lat=%0d diff=%h bout=%b ovf=%b, want ffff 1 0", lat, diff, bout, ovf);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || diff !== 16'hFFFF || bout !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL stall_hold: %0d bad cycles, want 0 (ov=%b diff=%h ir=%b)", bad, out_valid, diff, in_ready);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_ignore_inputs();
    bit ok; int lat; int qd;
    send(16'h4321, 16'h0321, 1'b0, ok);
    a = 16'h0000; b = 16'hFFFF; bin = 1'b1; in_valid = 1'b1;
    tick();
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL run_ready: in_ready=%b, want 0", in_ready);
    end
    tick();
    in_valid = 1'b0;
    wait_result(lat);
    a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (lat < 0 || diff !== 16'h4000 || bout !== 1'b0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL ignore: lat=%0d diff=%h bout=%b ovf=%b, want 4000 0 0", lat, diff, bout, ovf);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    qd = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid !== 1'b0) qd++;
    end
    n_vec++;
    if (qd != 0) begin
      n_err++;
      $display("FAIL no_queue: out_valid high %0d cycles, want 0", qd);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok; logic [15:0] rd; logic rb, ro; int lat;
    send(16'h9ABC, 16'h1234, 1'b0, ok);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 16'h0 || bout !== 1'b0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b diff=%h bout=%b ovf=%b, want 1 0 0000 0 0",
               in_ready, out_valid, diff, bout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    run_op(16'hFFFF, 16'h0000, 1'b0, rd, rb, ro, lat);
    n_vec++;
    if (rd !== 16'hFFFF || rb !== 1'b0 || ro !== 1'b0 || lat !== 4) begin
      n_err++;
      $display("FAIL after_reset_op: diff=%h bout=%b ovf=%b lat=%0d, want ffff 0 0 4", rd, rb, ro, lat);
    end
  endtask

  task automatic test_random();
    bit ok; int lat; int errs;
    logic [15:0] ra, rb;
    logic rbin;
    logic [16:0] full;
    int sd;
    logic exp_ovf;
    errs = 0;
    for (int n = 0; n < 2000; n++) begin
      ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
      if (n % 16 == 0) begin ra = 16'h0000; rb = 16'hFFFF; end
      full = {1'b0, ra} - {1'b0, rb} - {16'h0, rbin};
      sd   = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
      exp_ovf = (sd > 32767) || (sd < -32768);
      send(ra, rb, rbin, ok);
      wait_result(lat);
      repeat ($urandom_range(0, 3)) tick();
      n_vec++;
      if (!ok || lat < 0 || out_valid !== 1'b1 || diff !== full[15:0] || bout !== full[16] || ovf !== exp_ovf) begin
        n_err++;
        errs++;
        if (errs <= 10)
          $display("FAIL random: a=%h b=%h bin=%b got diff=%h bout=%b ovf=%b lat=%0d, want %h %b %b",
                   ra, rb, rbin, diff, bout, ovf, lat, full[15:0], full[16], exp_ovf);
        if (lat < 0) break;
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_borrow_ripple();
    test_overflow();
    test_backpressure();
    test_ignore_inputs();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
